// File: rtl/wash_cycle_controller.sv
// Wash sequencer: FILL -> WASH -> DRAIN -> (rinse refills) -> SPIN -> DONE.
// Drives the inlet valve, drain valve and drum motor, and steers the water-flow
// monitor (flow_mode selects fill/drain, mon_reset re-baselines it on every
// FILL or DRAIN entry). All outputs are registered and track the state register.
module wash_cycle_controller #(
  parameter int FULL_LEVEL  = 800,
  parameter int EMPTY_LEVEL = 20,
  parameter int WASH_CYCLES = 5000,
  parameter int SPIN_CYCLES = 3000,
  parameter int RINSES      = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       fault_clr,
  input  logic       door_closed,
  input  logic [9:0] water_level,
  input  logic       flow_error,
  output logic       inlet_valve,
  output logic       drain_valve,
  output logic       motor_on,
  output logic       motor_fast,
  output logic       flow_mode,
  output logic       mon_reset,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    DRAIN = 3'd3,
    SPIN  = 3'd4,
    DONE  = 3'd5,
    FAULT = 3'd6
  } state_t;

  localparam logic [9:0]  FULL_LV   = 10'(FULL_LEVEL);
  localparam logic [9:0]  EMPTY_LV  = 10'(EMPTY_LEVEL);
  localparam logic [31:0] WASH_LAST = 32'(WASH_CYCLES - 1);
  localparam logic [31:0] SPIN_LAST = 32'(SPIN_CYCLES - 1);
  localparam logic [3:0]  RINSE_MAX = 4'(RINSES);

  state_t      state;
  state_t      state_nx;
  logic [31:0] timer;
  logic [31:0] timer_nx;
  logic [31:0] timer_inc;
  logic [3:0]  rinse_cnt;
  logic [3:0]  rinse_nx;
  logic        abort_pend;
  logic        pend_nx;
  logic        flow_err_valid;

  // The monitor is being re-baselined while mon_reset is high, so its error
  // flag is meaningless in that cycle. The timer sticks at all-ones.
  assign flow_err_valid = flow_error & ~mon_reset;
  assign timer_inc      = (timer == 32'hFFFF_FFFF) ? timer : timer + 32'd1;

  // Next-state logic; within each state the checks are in priority order
  // (flow error, door, abort, then the normal progress condition).
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    rinse_nx = rinse_cnt;
    pend_nx  = abort_pend;
    case (state)
      IDLE: begin
        if (start && door_closed) begin
          state_nx = FILL;
          rinse_nx = 4'd0;
          pend_nx  = 1'b0;
        end
      end
      FILL: begin
        if (flow_err_valid) begin
          state_nx = FAULT;
        end else if (!door_closed) begin
          state_nx = FAULT;
        end else if (abort) begin
          state_nx = DRAIN;
          pend_nx  = 1'b1;
        end else if (water_level >= FULL_LV) begin
          state_nx = WASH;
          timer_nx = 32'd0;
        end
      end
      WASH: begin
        if (!door_closed) begin
          state_nx = FAULT;
        end else if (abort) begin
          state_nx = DRAIN;
          pend_nx  = 1'b1;
        end else if (timer == WASH_LAST) begin
          state_nx = DRAIN;
        end else begin
          timer_nx = timer_inc;
        end
      end
      DRAIN: begin
        // An open door is tolerated here so the drum can always empty.
        if (flow_err_valid) begin
          state_nx = FAULT;
        end else if (abort) begin
          pend_nx = 1'b1;
        end else if (water_level <= EMPTY_LV) begin
          if (abort_pend) begin
            state_nx = IDLE;
            pend_nx  = 1'b0;
          end else if (rinse_cnt < RINSE_MAX) begin
            state_nx = FILL;
            rinse_nx = rinse_cnt + 4'd1;
          end else begin
            state_nx = SPIN;
            timer_nx = 32'd0;
          end
        end
      end
      SPIN: begin
        if (!door_closed) begin
          state_nx = FAULT;
        end else if (abort) begin
          state_nx = DRAIN;
          pend_nx  = 1'b1;
        end else if (timer == SPIN_LAST) begin
          state_nx = DONE;
        end else begin
          timer_nx = timer_inc;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      FAULT: begin
        if (fault_clr) begin
          state_nx = IDLE;
          pend_nx  = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register plus outputs decoded from the next state, so every output
  // changes in the same cycle as the state it belongs to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      timer       <= 32'd0;
      rinse_cnt   <= 4'd0;
      abort_pend  <= 1'b0;
      inlet_valve <= 1'b0;
      drain_valve <= 1'b0;
      motor_on    <= 1'b0;
      motor_fast  <= 1'b0;
      flow_mode   <= 1'b0;
      mon_reset   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      state_dbg   <= 3'd0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      rinse_cnt   <= rinse_nx;
      abort_pend  <= pend_nx;
      inlet_valve <= (state_nx == FILL);
      drain_valve <= (state_nx == DRAIN) || (state_nx == SPIN);
      motor_on    <= (state_nx == WASH) || (state_nx == SPIN);
      motor_fast  <= (state_nx == SPIN);
      if (state_nx == FILL) begin
        flow_mode <= 1'b1;
      end else if (state_nx == DRAIN) begin
        flow_mode <= 1'b0;
      end
      mon_reset   <= ((state_nx == FILL) || (state_nx == DRAIN)) && (state_nx != state);
      busy        <= (state_nx != IDLE) && (state_nx != FAULT);
      done        <= (state_nx == DONE);
      fault       <= (state_nx == FAULT);
      state_dbg   <= state_nx;
    end
  end

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Bench for wash_cycle_controller: expected state entries (with the full output
// vector at entry) are queued as stimulus is driven and compared by a monitor
// when the DUT changes state.
module tb_wash_cycle_controller;

  localparam int FULL_LEVEL  = 100;
  localparam int EMPTY_LEVEL = 5;
  localparam int WASH_CYCLES = 4;
  localparam int SPIN_CYCLES = 3;
  localparam int RINSES      = 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_WASH  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_SPIN  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;

  // {inlet, drain, motor_on, motor_fast, flow_mode, mon_reset, busy, done, fault}
  localparam logic [8:0] O_IDLE0  = 9'b000000000;
  localparam logic [8:0] O_IDLE1  = 9'b000010000;
  localparam logic [8:0] O_FILL   = 9'b100011100;
  localparam logic [8:0] O_WASH   = 9'b001010100;
  localparam logic [8:0] O_DRAIN  = 9'b010001100;
  localparam logic [8:0] O_SPIN   = 9'b011100100;
  localparam logic [8:0] O_DONE   = 9'b000000110;
  localparam logic [8:0] O_FAULT0 = 9'b000000001;
  localparam logic [8:0] O_FAULT1 = 9'b000010001;
  localparam logic [8:0] O_RESET  = 9'b000001000;

  typedef struct packed {
    logic [2:0] st;
    logic [8:0] outs;
  } sb_item_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start, abort, fault_clr, door_closed, flow_error;
  logic [9:0] water_level;
  logic       inlet_valve, drain_valve, motor_on, motor_fast, flow_mode;
  logic       mon_reset, busy, done, fault;
  logic [2:0] state_dbg;
  logic [8:0] obs;

  sb_item_t   exp_q[$];
  sb_item_t   item;
  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  int         mon_cnt = 0;
  int         run_len = 0;
  bit         check_len = 1'b0;
  logic [2:0] prev_state = 3'd0;
  int         d0, m0;

  wash_cycle_controller #(
    .FULL_LEVEL (FULL_LEVEL),
    .EMPTY_LEVEL(EMPTY_LEVEL),
    .WASH_CYCLES(WASH_CYCLES),
    .SPIN_CYCLES(SPIN_CYCLES),
    .RINSES     (RINSES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .fault_clr  (fault_clr),
    .door_closed(door_closed),
    .water_level(water_level),
    .flow_error (flow_error),
    .inlet_valve(inlet_valve),
    .drain_valve(drain_valve),
    .motor_on   (motor_on),
    .motor_fast (motor_fast),
    .flow_mode  (flow_mode),
    .mon_reset  (mon_reset),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .state_dbg  (state_dbg)
  );

  assign obs = {inlet_valve, drain_valve, motor_on, motor_fast, flow_mode,
                mon_reset, busy, done, fault};

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] st, input logic [8:0] o);
    exp_q.push_back({st, o});
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n;
    n = 0;
    while (state_dbg !== s && n < 60) begin
      tick(1);
      n++;
    end
    check_output(tag, 32'(state_dbg), 32'(s));
  endtask

  // mode 0: plain cycle, 1: tank already full at start, 2: door opened during SPIN
  task automatic run_full(input int mode);
    push_exp(S_FILL, O_FILL);
    push_exp(S_WASH, O_WASH);
    push_exp(S_DRAIN, O_DRAIN);
    push_exp(S_FILL, O_FILL);
    push_exp(S_WASH, O_WASH);
    push_exp(S_DRAIN, O_DRAIN);
    push_exp(S_SPIN, O_SPIN);
    if (mode == 2) begin
      push_exp(S_FAULT, O_FAULT0);
      push_exp(S_IDLE, O_IDLE0);
    end else begin
      push_exp(S_DONE, O_DONE);
      push_exp(S_IDLE, O_IDLE0);
    end
    check_len = 1'b1;
    water_level = (mode == 1) ? 10'd100 : 10'd0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check_output("run_fill_entry", 32'(state_dbg), 32'(S_FILL));
    if (mode == 1) begin
      tick(1);
      check_output("full_on_entry", 32'(state_dbg), 32'(S_WASH));
    end else begin
      tick(2);
      water_level = 10'd100;
    end
    wait_state(S_DRAIN, "run_drain1");
    water_level = 10'd5;
    wait_state(S_FILL, "run_rinse_fill");
    water_level = 10'd100;
    wait_state(S_DRAIN, "run_drain2");
    water_level = 10'd5;
    wait_state(S_SPIN, "run_spin");
    if (mode == 2) begin
      check_len = 1'b0;
      tick(1);
      door_closed = 1'b0;
      tick(1);
      check_output("spin_door_fault", 32'(state_dbg), 32'(S_FAULT));
      check_output("spin_motor_off", 32'(motor_on), 0);
      tick(2);
      check_output("spin_fault_sticky", 32'(state_dbg), 32'(S_FAULT));
      fault_clr = 1'b1;
      tick(1);
      fault_clr = 1'b0;
      check_output("spin_fault_clr", 32'(state_dbg), 32'(S_IDLE));
    end else begin
      wait_state(S_IDLE, "run_idle");
    end
    water_level = 10'd0;
    tick(1);
  endtask

  // Scoreboard monitor: on every state change pop and compare the expected
  // entry, and check WASH/SPIN dwell times.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_state = state_dbg;
      run_len = 0;
    end else begin
      if (mon_reset) mon_cnt++;
      if (done) done_cnt++;
      if (state_dbg != prev_state) begin
        if (check_len && prev_state == S_WASH) check_output("wash_len", 32'(run_len), 32'(WASH_CYCLES));
        if (check_len && prev_state == S_SPIN) check_output("spin_len", 32'(run_len), 32'(SPIN_CYCLES));
        if (exp_q.size() == 0) begin
          check_output("sb_unexpected_state", 32'(state_dbg), 32'(prev_state));
        end else begin
          item = exp_q.pop_front();
          check_output("sb_state", 32'(state_dbg), 32'(item.st));
          check_output("sb_outs", 32'(obs), 32'(item.outs));
        end
        run_len = 1;
      end else begin
        run_len++;
      end
      prev_state = state_dbg;
    end
  end

  // Watchdog so the bench can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  // Main stimulus sequence.
  initial begin
    start = 1'b0;
    abort = 1'b0;
    fault_clr = 1'b0;
    door_closed = 1'b1;
    flow_error = 1'b0;
    water_level = 10'd0;
    #1 reset_n = 1'b0;
    #2;
    check_output("rst_state", 32'(state_dbg), 32'(S_IDLE));
    check_output("rst_outs", 32'(obs), 32'(O_RESET));
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check_output("mon_reset_drop", 32'(mon_reset), 0);
    check_output("idle_outs", 32'(obs), 32'(O_IDLE0));

    $display("[TB] full cycle with one rinse");
    d0 = done_cnt;
    m0 = mon_cnt;
    run_full(0);
    check_output("t1_done_pulses", 32'(done_cnt - d0), 1);
    check_output("t1_mon_resets", 32'(mon_cnt - m0), 4);
    check_output("t1_sb_empty", 32'(exp_q.size()), 0);

    $display("[TB] flow error in third FILL cycle");
    push_exp(S_FILL, O_FILL);
    push_exp(S_FAULT, O_FAULT1);
    push_exp(S_IDLE, O_IDLE1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    flow_error = 1'b1;
    tick(1);
    flow_error = 1'b0;
    check_output("t2_fault_state", 32'(state_dbg), 32'(S_FAULT));
    check_output("t2_actuators", 32'({inlet_valve, drain_valve, motor_on}), 0);
    check_output("t2_fault_flag", 32'(fault), 1);
    tick(3);
    check_output("t2_sticky", 32'(state_dbg), 32'(S_FAULT));
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check_output("t2_idle", 32'(state_dbg), 32'(S_IDLE));
    check_output("t2_busy", 32'(busy), 0);
    tick(1);
    check_output("t2_sb_empty", 32'(exp_q.size()), 0);

    $display("[TB] flow error only during mon_reset cycle");
    push_exp(S_FILL, O_FILL);
    push_exp(S_DRAIN, O_DRAIN);
    push_exp(S_IDLE, O_IDLE0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    flow_error = 1'b1;
    tick(1);
    flow_error = 1'b0;
    tick(2);
    check_output("t3_no_fault", 32'(state_dbg), 32'(S_FILL));
    check_output("t3_fault_flag", 32'(fault), 0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_output("t3_abort_drain", 32'(state_dbg), 32'(S_DRAIN));
    wait_state(S_IDLE, "t3_idle");
    tick(1);
    check_output("t3_sb_empty", 32'(exp_q.size()), 0);

    $display("[TB] abort during WASH");
    check_len = 1'b0;
    d0 = done_cnt;
    push_exp(S_FILL, O_FILL);
    push_exp(S_WASH, O_WASH);
    push_exp(S_DRAIN, O_DRAIN);
    push_exp(S_IDLE, O_IDLE0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    water_level = 10'd100;
    tick(2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_output("t4_abort_drain", 32'(state_dbg), 32'(S_DRAIN));
    tick(2);
    check_output("t4_hold_drain", 32'(state_dbg), 32'(S_DRAIN));
    water_level = 10'd0;
    wait_state(S_IDLE, "t4_idle");
    tick(1);
    check_output("t4_no_done", 32'(done_cnt - d0), 0);
    check_output("t4_sb_empty", 32'(exp_q.size()), 0);

    $display("[TB] door opened during SPIN, then start with door open");
    run_full(2);
    start = 1'b1;
    tick(3);
    check_output("t5_open_door_idle", 32'(state_dbg), 32'(S_IDLE));
    check_output("t5_open_door_busy", 32'(busy), 0);
    start = 1'b0;
    door_closed = 1'b1;
    check_output("t5_sb_empty", 32'(exp_q.size()), 0);

    $display("[TB] reset mid-FILL, then a cycle with the tank already full");
    push_exp(S_FILL, O_FILL);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    reset_n = 1'b0;
    #1;
    check_output("t6_rst_state", 32'(state_dbg), 32'(S_IDLE));
    check_output("t6_rst_outs", 32'(obs), 32'(O_RESET));
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check_output("t6_mon_reset_drop", 32'(mon_reset), 0);
    d0 = done_cnt;
    run_full(1);
    check_output("t6_done_pulses", 32'(done_cnt - d0), 1);
    check_output("t6_sb_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
